// File: rtl/smem_pkg.sv
// Shared types and widths for the paired-cacheline read path.
package smem_pkg;
    localparam int ADDR_W = 58;
    localparam int RN_W   = 6;
    localparam int CL_W   = 512;
    localparam int ID_W   = 3;   // enough for up to 8 requesters

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BEAT_K = 2'd1,
        BEAT_L = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [RN_W-1:0] read_num;
    } pair_tag_t;
endpackage

// File: rtl/pair_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each in-flight pair.
module pair_tag_fifo
    import smem_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  pair_tag_t push_tag,
    input  logic      pop,
    output pair_tag_t pop_tag,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    pair_tag_t      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // Overflow is impossible: the credit counter caps pushes at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_tag;
    end

    assign pop_tag = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
endmodule

// File: rtl/pair_req_arbiter.sv
// Round-robin arbiter issuing k/l address pairs and routing k/l responses back.
// Define PAIR_ARB_PRIO0_EN to give requester 0 strict priority.
module pair_req_arbiter
    import smem_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 16,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                      CLK_200M,
    input  logic                      spl_reset,
    input  logic                      stall,
    input  logic [NUM_REQ-1:0]        up_valid,
    output logic [NUM_REQ-1:0]        up_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] up_addr_k,
    input  logic [NUM_REQ*ADDR_W-1:0] up_addr_l,
    input  logic [NUM_REQ*RN_W-1:0]   up_read_num,
    output logic                      req_valid,
    output logic [ADDR_W-1:0]         req_addr,
    output logic [RN_W-1:0]           req_read_num,
    input  logic                      rsp_valid,
    input  logic [CL_W-1:0]           rsp_data,
    output logic [NUM_REQ-1:0]        dn_valid,
    output logic [CL_W-1:0]           dn_cl_k,
    output logic [CL_W-1:0]           dn_cl_l,
    output logic [RN_W-1:0]           dn_read_num,
    output logic [OUT_W-1:0]          outstanding,
    output logic                      err_orphan
);
`ifdef PAIR_ARB_PRIO0_EN
    localparam logic [ID_W-1:0] PTR_BASE = ID_W'(1);
`else
    localparam logic [ID_W-1:0] PTR_BASE = '0;
`endif

    issue_state_t      state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id, hi_id, lo_id;
    logic              found_hi;
    logic              accept;
    logic [ADDR_W-1:0] addr_l_hold;
    logic              parity;
    logic [CL_W-1:0]   k_hold;
    logic              complete;
    pair_tag_t         push_tag, pop_tag;
    logic              tag_empty;

    // Lowest valid id at or above the pointer, else lowest valid id overall.
    always_comb begin
        hi_id    = '0;
        lo_id    = '0;
        found_hi = 1'b0;
        for (int j = NUM_REQ - 1; j >= int'(PTR_BASE); j--) begin
            if (up_valid[j] && ID_W'(j) >= rr_ptr) begin
                hi_id    = ID_W'(j);
                found_hi = 1'b1;
            end
            if (up_valid[j]) lo_id = ID_W'(j);
        end
        win_id = found_hi ? hi_id : lo_id;
`ifdef PAIR_ARB_PRIO0_EN
        if (up_valid[0]) win_id = '0;
`endif
    end

    assign accept   = (state != BEAT_K) && !stall
                   && (outstanding < OUT_W'(MAX_OUTSTANDING)) && (|up_valid);
    assign up_ready = accept ? (NUM_REQ'(1) << win_id) : '0;

    always_ff @(posedge CLK_200M) begin
        if (spl_reset) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? BEAT_K : IDLE;
            BEAT_K:  state_nxt = BEAT_L;
            BEAT_L:  state_nxt = accept ? BEAT_K : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_200M) begin
        if (spl_reset) begin
            rr_ptr       <= PTR_BASE;
            req_valid    <= 1'b0;
            req_addr     <= '0;
            req_read_num <= '0;
            addr_l_hold  <= '0;
        end else begin
            req_valid <= accept || (state == BEAT_K);
            if (accept) begin
                req_addr     <= up_addr_k[win_id*ADDR_W +: ADDR_W];
                addr_l_hold  <= up_addr_l[win_id*ADDR_W +: ADDR_W];
                req_read_num <= up_read_num[win_id*RN_W +: RN_W];
`ifdef PAIR_ARB_PRIO0_EN
                if (win_id != '0)
`endif
                    rr_ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? PTR_BASE : win_id + 1'b1;
            end else if (state == BEAT_K) begin
                req_addr <= addr_l_hold;
            end
        end
    end

    assign push_tag.id       = win_id;
    assign push_tag.read_num = up_read_num[win_id*RN_W +: RN_W];
    assign complete          = rsp_valid && parity && !tag_empty;

    pair_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
        .clk      (CLK_200M),
        .rst      (spl_reset),
        .push     (accept),
        .push_tag (push_tag),
        .pop      (complete),
        .pop_tag  (pop_tag),
        .empty    (tag_empty)
    );

    // Response side: even beats park the k line, odd beats deliver the pair.
    always_ff @(posedge CLK_200M) begin
        if (spl_reset) begin
            parity      <= 1'b0;
            k_hold      <= '0;
            dn_valid    <= '0;
            dn_cl_k     <= '0;
            dn_cl_l     <= '0;
            dn_read_num <= '0;
            err_orphan  <= 1'b0;
            outstanding <= '0;
        end else begin
            dn_valid <= '0;
            if (rsp_valid) begin
                parity <= ~parity;
                if (!parity) begin
                    k_hold <= rsp_data;
                end else if (!tag_empty) begin
                    dn_valid    <= NUM_REQ'(1) << pop_tag.id;
                    dn_cl_k     <= k_hold;
                    dn_cl_l     <= rsp_data;
                    dn_read_num <= pop_tag.read_num;
                end else begin
                    err_orphan <= 1'b1;
                end
            end
            if (accept && !complete)      outstanding <= outstanding + 1'b1;
            else if (!accept && complete) outstanding <= outstanding - 1'b1;
        end
    end
endmodule

// File: tb/tb_pair_req_arbiter.sv
// Randomized bench for pair_req_arbiter against a queue-based behavioural model.
module tb_pair_req_arbiter;
    localparam int N = 4, MAXO = 16, AW = 58, RW = 6, OW = 5;

    logic              clk = 1'b0;
    logic              spl_reset, stall, rsp_valid, req_valid, err_orphan;
    logic [N-1:0]      up_valid, up_ready, dn_valid;
    logic [N*AW-1:0]   up_addr_k, up_addr_l;
    logic [N*RW-1:0]   up_read_num;
    logic [AW-1:0]     req_addr;
    logic [RW-1:0]     req_read_num, dn_read_num;
    logic [511:0]      rsp_data, dn_cl_k, dn_cl_l;
    logic [OW-1:0]     outstanding;

    always #5 clk = ~clk;

    pair_req_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .CLK_200M(clk), .spl_reset(spl_reset), .stall(stall),
        .up_valid(up_valid), .up_ready(up_ready), .up_addr_k(up_addr_k),
        .up_addr_l(up_addr_l), .up_read_num(up_read_num), .req_valid(req_valid),
        .req_addr(req_addr), .req_read_num(req_read_num), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .dn_valid(dn_valid), .dn_cl_k(dn_cl_k), .dn_cl_l(dn_cl_l),
        .dn_read_num(dn_read_num), .outstanding(outstanding), .err_orphan(err_orphan)
    );

    int errors = 0, checks = 0;

    typedef struct { int id; logic [RW-1:0] rn; } tag_s;
    tag_s          m_tags[$];
    int            grants[$];
    bit            m_kpend, m_par, m_err;
    int            m_outst, m_ptr;
    logic [AW-1:0] m_lpend;
    logic [511:0]  m_khold;
    bit            e_req_valid;
    logic [AW-1:0] e_req_addr;
    logic [RW-1:0] e_req_rn, e_dn_rn;
    logic [N-1:0]  e_dn_valid;
    logic [511:0]  e_dn_k, e_dn_l;

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Round-robin rule stated directly: first valid requester scanning from the pointer.
    function automatic int m_pick(logic [N-1:0] v);
`ifdef PAIR_ARB_PRIO0_EN
        if (v[0]) return 0;
        for (int i = 0; i < N - 1; i++) begin
            int idx = 1 + (m_ptr - 1 + i) % (N - 1);
            if (v[idx]) return idx;
        end
`else
        for (int i = 0; i < N; i++) begin
            int idx = (m_ptr + i) % N;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_tags.delete();
        m_kpend = 0; m_par = 0; m_err = 0; m_outst = 0; m_lpend = '0; m_khold = '0;
`ifdef PAIR_ARB_PRIO0_EN
        m_ptr = 1;
`else
        m_ptr = 0;
`endif
        e_req_valid = 0; e_req_addr = '0; e_req_rn = '0;
        e_dn_valid = '0; e_dn_k = '0; e_dn_l = '0; e_dn_rn = '0;
    endtask

    // Called just after a negedge with inputs set: check, advance model, wait a cycle.
    task automatic step();
        int  win, dec;
        bit  acc;
        tag_s t;
        #1;
        win = m_pick(up_valid);
        acc = !m_kpend && !stall && (m_outst < MAXO) && (up_valid != '0);
        if (!spl_reset) chk("up_ready", up_ready, acc ? (N'(1) << win) : '0);
        chk("req_valid", req_valid, e_req_valid);
        if (e_req_valid) begin
            chk("req_addr", req_addr, e_req_addr);
            chk("req_read_num", req_read_num, e_req_rn);
        end
        chk("dn_valid", dn_valid, e_dn_valid);
        if (e_dn_valid != '0) begin
            chk("dn_cl_k", dn_cl_k, e_dn_k);
            chk("dn_cl_l", dn_cl_l, e_dn_l);
            chk("dn_read_num", dn_read_num, e_dn_rn);
        end
        chk("outstanding", outstanding, m_outst);
        chk("err_orphan", err_orphan, m_err);
        if (spl_reset) begin
            model_reset();
        end else begin
            dec = 0;
            e_dn_valid = '0;
            if (rsp_valid) begin
                if (!m_par) m_khold = rsp_data;
                else if (m_tags.size() > 0) begin
                    t = m_tags.pop_front();
                    e_dn_valid = N'(1) << t.id;
                    e_dn_k = m_khold; e_dn_l = rsp_data; e_dn_rn = t.rn;
                    dec = 1;
                end else m_err = 1;
                m_par = !m_par;
            end
            if (acc) begin
                e_req_valid = 1;
                e_req_addr  = up_addr_k[win*AW +: AW];
                e_req_rn    = up_read_num[win*RW +: RW];
                m_lpend     = up_addr_l[win*AW +: AW];
                t.id = win; t.rn = e_req_rn;
                m_tags.push_back(t);
                grants.push_back(win);
                m_kpend = 1;
`ifdef PAIR_ARB_PRIO0_EN
                if (win != 0) m_ptr = (win == N - 1) ? 1 : win + 1;
`else
                m_ptr = (win + 1) % N;
`endif
            end else if (m_kpend) begin
                e_req_valid = 1; e_req_addr = m_lpend; m_kpend = 0;
            end else e_req_valid = 0;
            m_outst += (acc ? 1 : 0) - dec;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        up_valid = '0; stall = 0; rsp_valid = 0; rsp_data = '0;
    endtask

    task automatic do_reset();
        quiet(); spl_reset = 1; step(); spl_reset = 0;
    endtask

    task automatic rnd_fields();
        for (int i = 0; i < N; i++) begin
            up_addr_k[i*AW +: AW]   = AW'({$urandom, $urandom});
            up_addr_l[i*AW +: AW]   = AW'({$urandom, $urandom});
            up_read_num[i*RW +: RW] = RW'($urandom);
        end
    endtask

    logic [511:0] da, db;

    initial begin
        model_reset();
        up_addr_k = '0; up_addr_l = '0; up_read_num = '0;
        @(negedge clk);
        do_reset(); do_reset();
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_dn_valid", dn_valid, 0);
        chk("rst_dn_cl_k", dn_cl_k, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_orphan", err_orphan, 0);

        // single request from requester 2
        up_valid = 4'b0100;
        up_addr_k[2*AW +: AW] = 'h100; up_addr_l[2*AW +: AW] = 'h200; up_read_num[2*RW +: RW] = 5;
        #1 chk("single_ready", up_ready, 4'b0100);
        step(); up_valid = '0;
        chk("single_k_addr", req_addr, 'h100);
        chk("single_k_valid", req_valid, 1);
        chk("single_out1", outstanding, 1);
        step();
        chk("single_l_addr", req_addr, 'h200);
        da = rnd512(); db = rnd512();
        rsp_valid = 1; rsp_data = da; step();
        rsp_data = db; step(); rsp_valid = 0;
        chk("single_dn_valid", dn_valid, 4'b0100);
        chk("single_dn_k", dn_cl_k, da);
        chk("single_dn_l", dn_cl_l, db);
        chk("single_dn_rn", dn_read_num, 5);
        chk("single_out0", outstanding, 0);
        step();
        chk("single_pulse_end", dn_valid, 0);

        // all requesters held valid
        do_reset(); grants.delete(); rnd_fields(); up_valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("back_to_back_valid", req_valid, 1);
        end
`ifdef PAIR_ARB_PRIO0_EN
        for (int i = 0; i < 5; i++) chk("grant_seq", grants[i], 0);
`else
        for (int i = 0; i < 5; i++) chk("grant_seq", grants[i], i % N);
`endif

        // stall rising with the k beat on the output
        do_reset(); up_valid = 4'b0010; step();
        stall = 1; chk("stall_k_beat", req_valid, 1);
        step();
        chk("stall_l_beat_valid", req_valid, 1);
        chk("stall_l_beat_addr", req_addr, up_addr_l[1*AW +: AW]);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_blocks", up_ready, 0);
            step();
        end
        stall = 0;
        #1 chk("stall_release", up_ready, 4'b0010);
        step();

        // credit limit
        do_reset(); up_valid = 4'hF;
        for (int i = 0; i < 40; i++) step();
        chk("credit_full", outstanding, 16);
        #1 chk("credit_blocks", up_ready, 0);
        rsp_valid = 1; rsp_data = rnd512(); step(); rsp_data = rnd512(); step(); rsp_valid = 0;
        chk("credit_dec", outstanding, 15);
        #1 chk("credit_resume", up_ready != 0, 1);
        step();

        // accept coincident with completion
        do_reset(); up_valid = 4'b1000; step(); up_valid = '0; step(); step();
        rsp_valid = 1; rsp_data = rnd512(); step();
        rsp_data = rnd512(); up_valid = 4'b0001; step(); rsp_valid = 0; up_valid = '0;
        chk("coincident_out", outstanding, 1);
        chk("coincident_dn", dn_valid, 4'b1000);
        step();

        // orphan response
        do_reset();
        rsp_valid = 1; rsp_data = rnd512(); step(); step(); rsp_valid = 0;
        chk("orphan_flag", err_orphan, 1);
        chk("orphan_no_dn", dn_valid, 0);
        chk("orphan_out", outstanding, 0);
        step();

        // reset between k and l response beats
        do_reset(); up_valid = 4'b0100; step(); up_valid = '0; step(); step();
        rsp_valid = 1; rsp_data = rnd512(); step(); rsp_valid = 0;
        do_reset();
        chk("midrst_out", outstanding, 0);
        chk("midrst_req_valid", req_valid, 0);
        chk("midrst_dn_cl_k", dn_cl_k, 0);
        up_valid = 4'b0001; step(); up_valid = '0; step(); step();
        da = rnd512(); db = rnd512();
        rsp_valid = 1; rsp_data = da; step(); rsp_data = db; step(); rsp_valid = 0;
        chk("midrst_dn_valid", dn_valid, 4'b0001);
        chk("midrst_dn_k", dn_cl_k, da);
        chk("midrst_dn_l", dn_cl_l, db);
        step();

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rnd_fields();
            up_valid  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            stall     = ($urandom_range(0, 4) == 0);
            rsp_valid = (m_tags.size() > 0 || m_par) && ($urandom_range(0, 2) != 0);
            rsp_data  = rnd512();
            spl_reset = ($urandom_range(0, 499) == 0);
            step();
            spl_reset = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
